pcie_rm_tx_isolator: RTL
========================

// Module: pcie_rm_tx_isolator
// PURPOSE
//  Sits between the TX side of the reconfigurable PCIe application module and the
//  PCIe core TRN TX port. It passes TLPs through and, on request from the
//  reconfiguration controller, brings the TX path to a packet-clean quiescent state.
//  A partial TLP that will not finish is terminated with a discontinue. The TX path
//  is then held isolated until the new module is loaded.
// PARAMETERS
//  DRAIN_TIMEOUT  1024  idle DRAIN cycles (no accepted beat) before the packet is aborted
//  TO_W           16    width of the drain idle counter (must hold DRAIN_TIMEOUT-1)
// PORTS
//  trn_clk            in   1   TRN clock; all logic on the rising edge
//  trn_reset          in   1   synchronous reset, active-high
//  isolate_req        in   1   1 = isolate the RM TX path, 0 = normal operation
//  isolate_ack        out  1   1 = TX path quiescent and isolated
//  rm_td              in   64  RM TX data
//  rm_trem_n          in   1   RM remainder (0 = both DWs valid)
//  rm_tsof_n          in   1   RM start of frame
//  rm_teof_n          in   1   RM end of frame
//  rm_tsrc_rdy_n      in   1   RM source ready
//  rm_tsrc_dsc_n      in   1   RM source discontinue
//  rm_tdst_rdy_n      out  1   destination ready back to RM
//  trn_td             out  64  to core TX data
//  trn_trem_n         out  1   to core remainder
//  trn_tsof_n         out  1   to core start of frame
//  trn_teof_n         out  1   to core end of frame
//  trn_tsrc_rdy_n     out  1   to core source ready
//  trn_tsrc_dsc_n     out  1   to core discontinue
//  trn_tdst_rdy_n     in   1   core destination ready
//  dsc_count          out  8   saturating count of aborted (discontinued) TLPs
// BEHAVIOUR
//  - beat accepted = rm_tsrc_rdy_n==0 && trn_tdst_rdy_n==0 while the path is passed through.
//  - in_pkt: set on an accepted beat with sof=0, eof=1; cleared on an accepted eof=0;
//    in_pkt_next = in_pkt after this cycle's accepted beat.
//  - Output muxing is combinational from registered state; pass-through latency is 0 cycles.
//  - Reset: state=PASS, in_pkt=0, idle counter=0, dsc_count=0, isolate_ack=0.
//    All core-side _n outputs follow pass-through of RM inputs. Reset mid-packet drops
//    the packet without a discontinue.
//  - State PASS:
//    - core outputs = RM inputs; rm_tdst_rdy_n = trn_tdst_rdy_n.
//    - isolate_req=1 and in_pkt_next=0 -> ISOL.
//    - isolate_req=1 and in_pkt_next=1 -> DRAIN; idle counter cleared.
//  - State DRAIN:
//    - pass-through as in PASS. The idle counter increments on each cycle with no
//      accepted beat and clears on an accepted beat.
//    - accepted eof -> ISOL (if isolate_req=1) else PASS.
//    - isolate_req=0 with no eof -> PASS (packet continues).
//    - counter==DRAIN_TIMEOUT-1 with no accepted beat -> ABORT.
//  - State ABORT:
//    - rm_tdst_rdy_n=1.
//    - core sees trn_tsrc_rdy_n=0, trn_teof_n=0, trn_tsrc_dsc_n=0, trn_tsof_n=1,
//      trn_trem_n=0, trn_td=0.
//    - held until trn_tdst_rdy_n==0. On that cycle: in_pkt<=0, dsc_count+1
//      (saturates at 255), -> ISOL.
//  - State ISOL:
//    - rm_tdst_rdy_n=1; trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_tsrc_dsc_n=1,
//      trn_td=0, trn_trem_n=1.
//    - in_pkt forced 0; isolate_ack=1.
//    - isolate_req=0 -> PASS; isolate_ack drops in the same cycle PASS is entered.
//  - isolate_ack is 1 only in ISOL. ISOL is never entered with a partial TLP outstanding
//    at the core.
//  - A single-beat TLP (sof=eof=0) accepted in PASS while isolate_req rises -> ISOL,
//    not DRAIN.
//  - RM inputs in ISOL/ABORT are ignored (X-tolerant). Core outputs in those states are
//    fully defined.
// TESTING
//  - Pass-through: RM sends a 3-beat TLP with core ready -> identical beats at core,
//    same cycles; isolate_ack=0.
//  - Isolate idle: isolate_req=1 with no packet -> isolate_ack=1 next cycle;
//    trn_tsrc_rdy_n=1 and rm_tdst_rdy_n=1 while held.
//  - Isolate mid-TLP: req after beat 1 of 4 -> beats 2-4 forwarded; isolate_ack=1 the
//    cycle after eof is accepted; dsc_count=0.
//  - Timeout: req mid-TLP, RM stops with DRAIN_TIMEOUT=16 -> ABORT after 16 idle cycles;
//    one eof+dsc beat (held while trn_tdst_rdy_n=1); then isolate_ack=1, dsc_count=1.
//  - Release: drop isolate_req in ISOL -> PASS next cycle; a fresh TLP passes intact.
//  - Reset in DRAIN: trn_reset=1 for 1 cycle -> state PASS, isolate_ack=0, dsc_count=0,
//    counter 0.

Source files
------------

// File: rtl/pcie_rm_tx_isolator.sv
// ---------------------------------------------------------------------------
// pcie_rm_tx_isolator
//
// Purpose:
//   Sits between the TX side of a reconfigurable PCIe application module (RM)
//   and the PCIe core TRN TX port. In normal operation TLPs pass straight
//   through with zero latency. When the reconfiguration controller raises
//   isolate_req, the block waits for any TLP already in flight to finish. If
//   the RM stops mid-packet for too long, the packet is terminated at the core
//   with a single eof+discontinue beat. The TX path is then held isolated
//   (isolate_ack=1) until isolate_req is released.
//
// Ports:
//   trn_clk, trn_reset       clock, synchronous active-high reset
//   isolate_req/isolate_ack  isolation handshake with the reconfig controller
//   rm_*                     TRN TX interface from the RM (rm_tdst_rdy_n back)
//   trn_*                    TRN TX interface to the core (trn_tdst_rdy_n in)
//   dsc_count                saturating count of TLPs aborted with discontinue
// ---------------------------------------------------------------------------
module pcie_rm_tx_isolator #(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int TO_W          = 16,
  parameter int DATA_W        = 64
) (
  input  logic              trn_clk,
  input  logic              trn_reset,
  input  logic              isolate_req,
  output logic              isolate_ack,
  input  logic [DATA_W-1:0] rm_td,
  input  logic              rm_trem_n,
  input  logic              rm_tsof_n,
  input  logic              rm_teof_n,
  input  logic              rm_tsrc_rdy_n,
  input  logic              rm_tsrc_dsc_n,
  output logic              rm_tdst_rdy_n,
  output logic [DATA_W-1:0] trn_td,
  output logic              trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  output logic              trn_tsrc_dsc_n,
  input  logic              trn_tdst_rdy_n,
  output logic [7:0]        dsc_count
);

  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_DRAIN = 2'd1,
    S_ABORT = 2'd2,
    S_ISOL  = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_in_pkt;
  logic            w_in_pkt_nx;
  logic [TO_W-1:0] r_idle;
  logic [TO_W-1:0] w_idle_nx;
  logic [7:0]      r_dsc;
  logic [7:0]      w_dsc_nx;

  logic            w_pass;
  logic            w_acc;
  logic            w_pkt_after;

  // Beats are only accepted while the path is transparent (PASS/DRAIN).
  assign w_pass = (r_state == S_PASS) || (r_state == S_DRAIN);
  assign w_acc  = w_pass && !rm_tsrc_rdy_n && !trn_tdst_rdy_n;

  // Packet-open flag as it will be after this cycle's accepted beat. An eof
  // closes the packet even when it is also the sof (single-beat TLP).
  always_comb begin
    w_pkt_after = r_in_pkt;
    if (w_acc) begin
      if (!rm_teof_n)      w_pkt_after = 1'b0;
      else if (!rm_tsof_n) w_pkt_after = 1'b1;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (trn_reset) begin
      r_state  <= S_PASS;
      r_in_pkt <= 1'b0;
      r_idle   <= '0;
      r_dsc    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_in_pkt <= w_in_pkt_nx;
      r_idle   <= w_idle_nx;
      r_dsc    <= w_dsc_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_in_pkt_nx = r_in_pkt;
    w_idle_nx   = r_idle;
    w_dsc_nx    = r_dsc;
    case (r_state)
      S_PASS: begin
        w_in_pkt_nx = w_pkt_after;
        if (isolate_req) begin
          if (w_pkt_after) begin
            w_state_nx = S_DRAIN;
            w_idle_nx  = '0;
          end else begin
            w_state_nx = S_ISOL;
          end
        end
      end
      S_DRAIN: begin
        w_in_pkt_nx = w_pkt_after;
        w_idle_nx   = w_acc ? '0 : r_idle + 1'b1;
        // Packet completion wins over a withdrawn request or a timeout.
        if (w_acc && !rm_teof_n)
          w_state_nx = isolate_req ? S_ISOL : S_PASS;
        else if (!isolate_req)
          w_state_nx = S_PASS;
        else if (!w_acc && (r_idle == TO_LAST))
          w_state_nx = S_ABORT;
      end
      S_ABORT: begin
        // The discontinue beat is held until the core takes it.
        if (!trn_tdst_rdy_n) begin
          w_in_pkt_nx = 1'b0;
          w_dsc_nx    = sat_inc(r_dsc);
          w_state_nx  = S_ISOL;
        end
      end
      S_ISOL: begin
        w_in_pkt_nx = 1'b0;
        if (!isolate_req) w_state_nx = S_PASS;
      end
      default: w_state_nx = S_PASS;
    endcase
  end

  // Output mux: transparent in PASS/DRAIN, fully defined (RM ignored) otherwise.
  always_comb begin
    trn_td         = rm_td;
    trn_trem_n     = rm_trem_n;
    trn_tsof_n     = rm_tsof_n;
    trn_teof_n     = rm_teof_n;
    trn_tsrc_rdy_n = rm_tsrc_rdy_n;
    trn_tsrc_dsc_n = rm_tsrc_dsc_n;
    rm_tdst_rdy_n  = trn_tdst_rdy_n;
    case (r_state)
      S_ABORT: begin
        trn_td         = '0;
        trn_trem_n     = 1'b0;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
        trn_tsrc_dsc_n = 1'b0;
        rm_tdst_rdy_n  = 1'b1;
      end
      S_ISOL: begin
        trn_td         = '0;
        trn_trem_n     = 1'b1;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        trn_tsrc_dsc_n = 1'b1;
        rm_tdst_rdy_n  = 1'b1;
      end
      default: ;
    endcase
  end

  assign isolate_ack = (r_state == S_ISOL);
  assign dsc_count   = r_dsc;

endmodule
